// File: rtl/ex_out_pkg.sv
// Shared types and register map for the ex_data_pwm output port.
// Offsets are relative to the block's base address on the CPU bus.
package ex_out_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_PWM    = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  localparam int OFF_OUT    = 0;
  localparam int OFF_EN     = 1;
  localparam int OFF_PRE_LO = 2;
  localparam int OFF_PRE_HI = 3;
  localparam int OFF_MODE0  = 4;  // MODE[n] at 4+2n, DUTY[n] at 5+2n

  localparam logic [7:0] TB_MAX = 8'd254;

endpackage

// File: rtl/ex_out_ch.sv
// One output channel: duty shadow, blink divider/phase and the registered output mux.
// All timing comes from the shared timebase in the top level.
module ex_out_ch
  import ex_out_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       en_i,
  input  logic       out_i,
  input  logic [1:0] mode_i,
  input  logic [7:0] duty_i,
  input  logic       mode_wr_i,
  input  logic [7:0] tb_cnt_i,
  input  logic       wrap_i,
  output logic       ex_o
);

  logic [7:0] duty_sh_q, duty_sh_d;
  logic [7:0] blink_div_q, blink_div_d;
  logic       blink_ph_q, blink_ph_d;
  logic       ex_q, ex_d;
  logic       nxt;

  always_comb begin
    duty_sh_d   = duty_sh_q;
    blink_div_d = blink_div_q;
    blink_ph_d  = blink_ph_q;
    nxt         = out_i;

    if (wrap_i) duty_sh_d = duty_i;

    // Divider compares against the shadow in force before this wrap reloads it.
    if (mode_wr_i) begin
      blink_div_d = '0;
      blink_ph_d  = 1'b0;
    end else if (wrap_i) begin
      if (blink_div_q == duty_sh_q) begin
        blink_div_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_div_d = blink_div_q + 8'd1;
      end
    end

    case (mode_t'(mode_i))
      MODE_PWM:   nxt = (tb_cnt_i < duty_sh_q);
      MODE_BLINK: nxt = blink_ph_q;
      default:    nxt = out_i;
    endcase

    ex_d = en_i & nxt;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      duty_sh_q   <= '0;
      blink_div_q <= '0;
      blink_ph_q  <= 1'b0;
      ex_q        <= 1'b0;
    end else begin
      duty_sh_q   <= duty_sh_d;
      blink_div_q <= blink_div_d;
      blink_ph_q  <= blink_ph_d;
      ex_q        <= ex_d;
    end
  end

  assign ex_o = ex_q;

endmodule

// File: rtl/ex_data_pwm.sv
// Bus-mapped multi-channel output port: registers, address decode, prescaler and the
// shared 0..254 timebase; per-channel behaviour lives in ex_out_ch.
module ex_data_pwm
  import ex_out_pkg::*;
#(
  parameter int          NumChannels   = 4,
  parameter int unsigned BaseAddress   = 32'h9100,
  parameter int          address_width = 16,
  parameter int          data_width    = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [address_width-1:0] addr_i,
  input  logic                     we_i,
  input  logic [data_width-1:0]    data_i,
  output logic [data_width-1:0]    data_o,
  output logic [NumChannels-1:0]   ex_data_o
);

  localparam logic [address_width-1:0] BASE = address_width'(BaseAddress);

  logic [address_width-1:0] off;
  logic [NumChannels-1:0]   out_q, en_q;
  logic [7:0]               pre_lo_q, pre_hi_q;
  logic [1:0]               mode_q [NumChannels];
  logic [7:0]               duty_q [NumChannels];
  logic [NumChannels-1:0]   mode_wr, duty_wr;
  logic [7:0]               rd_val;
  logic [data_width-1:0]    data_q;
  logic [15:0]              pre_cnt_q, pre_cnt_d;
  logic [7:0]               tb_cnt_q, tb_cnt_d;
  logic                     pre_wr, tick, wrap;

  assign off = addr_i - BASE;

  always_comb begin
    mode_wr = '0;
    duty_wr = '0;
    rd_val  = '0;
    if (off == address_width'(OFF_OUT))    rd_val = 8'(out_q);
    if (off == address_width'(OFF_EN))     rd_val = 8'(en_q);
    if (off == address_width'(OFF_PRE_LO)) rd_val = pre_lo_q;
    if (off == address_width'(OFF_PRE_HI)) rd_val = pre_hi_q;
    for (int i = 0; i < NumChannels; i++) begin
      mode_wr[i] = we_i && (off == address_width'(OFF_MODE0 + 2*i));
      duty_wr[i] = we_i && (off == address_width'(OFF_MODE0 + 2*i + 1));
      if (off == address_width'(OFF_MODE0 + 2*i))     rd_val = {6'b0, mode_q[i]};
      if (off == address_width'(OFF_MODE0 + 2*i + 1)) rd_val = duty_q[i];
    end
  end

  // A PRE write restarts the count so the new divide ratio begins cleanly.
  always_comb begin
    pre_wr    = we_i && (off == address_width'(OFF_PRE_LO) || off == address_width'(OFF_PRE_HI));
    tick      = (pre_cnt_q == {pre_hi_q, pre_lo_q});
    wrap      = tick && (tb_cnt_q == TB_MAX);
    pre_cnt_d = (pre_wr || tick) ? 16'd0 : pre_cnt_q + 16'd1;
    tb_cnt_d  = tb_cnt_q;
    if (tick) tb_cnt_d = wrap ? 8'd0 : tb_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_q     <= '0;
      en_q      <= '0;
      pre_lo_q  <= '0;
      pre_hi_q  <= '0;
      data_q    <= '0;
      pre_cnt_q <= '0;
      tb_cnt_q  <= '0;
      for (int i = 0; i < NumChannels; i++) begin
        mode_q[i] <= '0;
        duty_q[i] <= '0;
      end
    end else begin
      data_q    <= data_width'(rd_val);
      pre_cnt_q <= pre_cnt_d;
      tb_cnt_q  <= tb_cnt_d;
      if (we_i && off == address_width'(OFF_OUT))    out_q    <= data_i[NumChannels-1:0];
      if (we_i && off == address_width'(OFF_EN))     en_q     <= data_i[NumChannels-1:0];
      if (we_i && off == address_width'(OFF_PRE_LO)) pre_lo_q <= data_i[7:0];
      if (we_i && off == address_width'(OFF_PRE_HI)) pre_hi_q <= data_i[7:0];
      for (int i = 0; i < NumChannels; i++) begin
        if (mode_wr[i]) mode_q[i] <= data_i[1:0];
        if (duty_wr[i]) duty_q[i] <= data_i[7:0];
      end
    end
  end

  assign data_o = data_q;

  for (genvar g = 0; g < NumChannels; g++) begin : g_ch
    ex_out_ch u_ch (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .en_i      (en_q[g]),
      .out_i     (out_q[g]),
      .mode_i    (mode_q[g]),
      .duty_i    (duty_q[g]),
      .mode_wr_i (mode_wr[g]),
      .tb_cnt_i  (tb_cnt_q),
      .wrap_i    (wrap),
      .ex_o      (ex_data_o[g])
    );
  end

endmodule

// File: tb/tb_ex_data_pwm.sv
// Directed bench for ex_data_pwm: reset, DIRECT, PWM, prescaler, BLINK, decode and mid-run reset.
module tb_ex_data_pwm;

  localparam logic [15:0] BASE = 16'h9100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = BASE;
  logic        we = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic [3:0]  ex;

  int total = 0;
  int bad   = 0;

  ex_data_pwm #(.NumChannels(4), .BaseAddress(32'h9100), .address_width(16), .data_width(8)) dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .addr_i    (addr),
    .we_i      (we),
    .data_i    (data_in),
    .data_o    (data_out),
    .ex_data_o (ex)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    addr    = BASE + 16'(off);
    data_in = d;
    we      = 1'b1;
    step();
    we      = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] v);
    addr = a;
    step();
    v = data_out;
  endtask

  task automatic wait_rise(input int ch, input int limit, output bit ok);
    logic prev;
    ok   = 1'b0;
    prev = ex[ch];
    for (int i = 0; i < limit; i++) begin
      step();
      if (!prev && ex[ch]) begin
        ok = 1'b1;
        return;
      end
      prev = ex[ch];
    end
  endtask

  // Length of the run of samples equal to v, starting at the current sample.
  task automatic run_len(input int ch, input logic v, input int limit, output int n);
    n = 0;
    while (ex[ch] === v && n < limit) begin
      n++;
      step();
    end
  endtask

  task automatic count_high(input int ch, input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (ex[ch] === 1'b1) n++;
      step();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    #2;
    total++;
    if (ex !== 4'b0000) begin bad++; $display("FAIL reset_ex: got %b exp 0000", ex); end
    total++;
    if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %h exp 00", data_out); end
    step(); step();
    rst = 1'b0;
    step();
    for (int o = 0; o < 12; o++) begin
      rd(BASE + 16'(o), v);
      total++;
      if (v !== 8'h00) begin bad++; $display("FAIL reset_reg%0d: got %h exp 00", o, v); end
    end
  endtask

  task automatic test_direct();
    logic [7:0] v;
    wr(1, 8'h0F);
    wr(0, 8'h05);
    step(); step();
    total++;
    if (ex !== 4'b0101) begin bad++; $display("FAIL direct_ex: got %b exp 0101", ex); end
    rd(BASE + 16'd0, v);
    total++;
    if (v !== 8'h05) begin bad++; $display("FAIL direct_rd_out: got %h exp 05", v); end
    // Write and read the same address in one cycle: the old value comes back.
    wr(0, 8'h0A);
    total++;
    if (data_out !== 8'h05) begin bad++; $display("FAIL wr_rd_same: got %h exp 05", data_out); end
    rd(BASE + 16'd0, v);
    total++;
    if (v !== 8'h0A) begin bad++; $display("FAIL direct_rd_out2: got %h exp 0a", v); end
    total++;
    if (ex !== 4'b1010) begin bad++; $display("FAIL direct_ex2: got %b exp 1010", ex); end
  endtask

  task automatic test_pwm();
    bit ok;
    int n;
    wr(4, 8'h01);
    wr(5, 8'd64);
    wait_rise(0, 600, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL pwm_rise1: got timeout exp edge"); end
    run_len(0, 1'b1, 300, n);
    total++;
    if (n !== 64) begin bad++; $display("FAIL pwm_high64: got %0d exp 64", n); end
    // New duty written just after the period starts must not affect this period.
    wait_rise(0, 600, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL pwm_rise2: got timeout exp edge"); end
    wr(5, 8'd255);
    run_len(0, 1'b1, 300, n);
    total++;
    if (n + 1 !== 64) begin bad++; $display("FAIL pwm_defer: got %0d exp 64", n + 1); end
    repeat (300) step();
    count_high(0, 255, n);
    total++;
    if (n !== 255) begin bad++; $display("FAIL pwm_duty255: got %0d exp 255", n); end
    wr(5, 8'd0);
    repeat (300) step();
    count_high(0, 255, n);
    total++;
    if (n !== 0) begin bad++; $display("FAIL pwm_duty0: got %0d exp 0", n); end
  endtask

  task automatic test_prescaler();
    bit ok;
    int n;
    wr(5, 8'd64);
    wr(2, 8'd3);
    wait_rise(0, 2500, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL pre_rise1: got timeout exp edge"); end
    run_len(0, 1'b1, 1100, n);
    total++;
    if (n !== 256) begin bad++; $display("FAIL pre_high256: got %0d exp 256", n); end
    run_len(0, 1'b0, 1100, n);
    total++;
    if (n !== 764) begin bad++; $display("FAIL pre_low764: got %0d exp 764", n); end
    // PRE write one cycle into the period restarts pre_cnt, stretching tb_cnt=0 by 2 cycles.
    wr(2, 8'd3);
    run_len(0, 1'b1, 1100, n);
    total++;
    if (n + 1 !== 258) begin bad++; $display("FAIL pre_restart: got %0d exp 258", n + 1); end
    wr(2, 8'd0);
  endtask

  task automatic test_blink();
    bit ok;
    int n;
    wr(6, 8'h02);
    wr(7, 8'h01);
    wait_rise(1, 1200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL blink_rise1: got timeout exp edge"); end
    run_len(1, 1'b1, 1200, n);
    total++;
    if (n !== 510) begin bad++; $display("FAIL blink_high510: got %0d exp 510", n); end
    run_len(1, 1'b0, 1200, n);
    total++;
    if (n !== 510) begin bad++; $display("FAIL blink_low510: got %0d exp 510", n); end
    wait_rise(1, 1200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL blink_rise2: got timeout exp edge"); end
    wr(1, 8'h0D);
    step();
    total++;
    if (ex[1] !== 1'b0) begin bad++; $display("FAIL blink_en_off: got %b exp 0", ex[1]); end
  endtask

  task automatic test_decode();
    logic [7:0] v;
    wr(12, 8'hFF);
    wr(16'h20, 8'hFF);
    rd(BASE + 16'd12, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL dec_off12: got %h exp 00", v); end
    rd(BASE + 16'h20, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL dec_off20: got %h exp 00", v); end
    rd(16'h90FF, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL dec_below: got %h exp 00", v); end
    rd(BASE + 16'd1, v);
    total++;
    if (v !== 8'h0D) begin bad++; $display("FAIL dec_en_kept: got %h exp 0d", v); end
    wr(0, 8'hFF);
    rd(BASE + 16'd0, v);
    total++;
    if (v !== 8'h0F) begin bad++; $display("FAIL dec_out_mask: got %h exp 0f", v); end
    wr(8, 8'h03);
    rd(BASE + 16'd8, v);
    total++;
    if (v !== 8'h03) begin bad++; $display("FAIL dec_mode_rsvd: got %h exp 03", v); end
    step();
    total++;
    if (ex[2] !== 1'b1) begin bad++; $display("FAIL rsvd_direct: got %b exp 1", ex[2]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    wr(4, 8'h00);
    rd(BASE + 16'd1, v);
    step();
    total++;
    if (ex[0] !== 1'b1) begin bad++; $display("FAIL pre_rst_ex0: got %b exp 1", ex[0]); end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (ex !== 4'b0000) begin bad++; $display("FAIL rst_mid_ex: got %b exp 0000", ex); end
    total++;
    if (data_out !== 8'h00) begin bad++; $display("FAIL rst_mid_data: got %h exp 00", data_out); end
    step(); step();
    rst = 1'b0;
    for (int o = 0; o < 12; o++) begin
      rd(BASE + 16'(o), v);
      total++;
      if (v !== 8'h00) begin bad++; $display("FAIL rst_mid_reg%0d: got %h exp 00", o, v); end
    end
    total++;
    if (ex !== 4'b0000) begin bad++; $display("FAIL rst_mid_ex_after: got %b exp 0000", ex); end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_pwm();
    test_prescaler();
    test_blink();
    test_decode();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
